fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port d.valid  output  1  pipeline_if.Downstream valid, asserted while uopOut holds a uop.
REQ-005 SHALL have port d.stall  input  1  pipeline_if.Downstream stall; when high, d.valid and uopOut hold.
REQ-006 SHALL have port uopOut  output  Uop::fetch_t  fields pc[31:0], enc[31:0], misaligned.
REQ-007 SHALL have port imemReqValid  output  1  instruction request valid.
REQ-008 SHALL have port imemReqAddr  output  32  request address, equal to the pc register.
REQ-009 SHALL have port imemReqReady  input  1  request accepted when high with imemReqValid.
REQ-010 SHALL have port imemRespValid  input  1  response data valid; arrives at least 1 cycle after acceptance.
REQ-011 SHALL have port imemRespData  input  32  instruction word.
REQ-012 SHALL have port redirectValid  input  1  flush and restart at redirectPc.
REQ-013 SHALL have port redirectPc  input  32  redirect target.

Function
REQ-014 SHALL implement states FETCH, WAIT, DRAIN, HOLD, with at most one outstanding request.
REQ-015 FETCH SHALL drive imemReqValid=1 with imemReqAddr=pc, and SHALL move to WAIT on imemReqReady.
REQ-016 In WAIT, on imemRespValid with d.stall=0, the block SHALL load uopOut={pc, imemRespData, 0}, set d.valid=1, set pc<=pc+4 (mod 2^32) and move to FETCH.
REQ-017 In WAIT, on imemRespValid with d.stall=1 and d.valid=1, the block SHALL capture the uop in a one-entry skid register and move to HOLD.
REQ-018 In HOLD, the first cycle with d.stall=0 SHALL move the skid uop to uopOut, keep d.valid=1, set pc<=pc+4 and move to FETCH.
REQ-019 With d.stall=0 and no new uop loaded, d.valid SHALL clear next cycle (the uop counts as transferred).
REQ-020 imemRespValid SHALL be ignored in FETCH and HOLD.
REQ-021 redirectValid SHALL have the highest priority: it sets pc<=redirectPc, clears d.valid even when d.stall=1, and empties the skid register.
REQ-022 On redirect, the state SHALL change as follows: FETCH->FETCH; FETCH with imemReqReady the same cycle->DRAIN; WAIT->DRAIN; HOLD->FETCH; DRAIN->DRAIN.
REQ-023 A response arriving in the same cycle as a redirect SHALL be discarded; the state then goes to FETCH whenever it would otherwise have gone to DRAIN.
REQ-024 DRAIN SHALL discard the next imemRespValid, issue no request, and then move to FETCH.
REQ-025 Peak throughput SHALL be one uop per 2 cycles with a 1-cycle memory; uopOut is registered.

Reset
REQ-026 rst low SHALL asynchronously force: state=FETCH, pc=RESET_PC, d.valid=0, uopOut=0, skid empty, imemReqValid=0.
REQ-027 imemReqValid SHALL first assert on the first clk edge after rst deasserts; memory SHALL be reset together with this block.

Configuration
REQ-028 With FETCH_MISALIGN_CHECK_EN defined, a redirect with redirectPc[1:0]!=0 SHALL issue no request and emit one uop {redirectPc, 32'h0, misaligned=1}; the block SHALL then idle in FETCH with imemReqValid=0 until the next redirect.
REQ-029 Without FETCH_MISALIGN_CHECK_EN, redirectPc[1:0] SHALL be forced to 0 and uopOut.misaligned SHALL be tied 0.

Verification
REQ-030 SHALL cover: release reset with RESET_PC=0x100, memory ready and 1-cycle latency -> uops pc 0x100, 0x104, 0x108 issued on alternate cycles.
REQ-031 SHALL cover: d.stall=1 for 5 cycles while a response arrives -> uopOut holds the old uop; new uop appears on the first stall-low cycle; no uop is lost or duplicated.
REQ-032 SHALL cover: redirect to 0x200 while in WAIT -> the stale response is dropped and the next uop has pc=0x200.
REQ-033 SHALL cover: redirect in the same cycle as imemRespValid -> response discarded and the next request address is 0x200.
REQ-034 SHALL cover: pc=0xFFFF_FFFC fetched -> the next request address is 0x0000_0000.
REQ-035 SHALL cover: with FETCH_MISALIGN_CHECK_EN, redirect to 0x202 -> one uop with misaligned=1, pc=0x202, and no imem request.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Shared uop bundle type and valid/stall handshake interface
// used by the fetch stage and its downstream consumer.

package Uop;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] enc;
        logic        misaligned;
    } fetch_t;

endpackage

interface pipeline_if;

    logic valid;
    logic stall;

    modport Downstream (output valid, input stall);
    modport Upstream (input valid, output stall);

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: one-outstanding instruction fetch with a one-entry skid.
// Optional macro FETCH_MISALIGN_CHECK_EN reports misaligned redirects.

module fetch_stage
    import Uop::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_if.Downstream d,
    output fetch_t         uopOut,
    output logic           imemReqValid,
    output logic [31:0]    imemReqAddr,
    input  logic           imemReqReady,
    input  logic           imemRespValid,
    input  logic [31:0]    imemRespData,
    input  logic           redirectValid,
    input  logic [31:0]    redirectPc
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN,
        HOLD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        valid_q;
    logic        valid_d;
    fetch_t      uop_q;
    fetch_t      uop_d;
    fetch_t      skid_q;
    fetch_t      skid_d;
    logic        idle_q;
    logic        idle_d;
    logic        live_q;
    logic        req_fire;
    logic [31:0] redir_pc;
    logic        redir_bad;
    fetch_t      resp_uop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_bad = (redirectPc[1:0] != 2'b00);
    assign redir_pc  = redirectPc;
`else
    assign redir_bad = 1'b0;
    assign redir_pc  = redirectPc & 32'hFFFF_FFFC;
`endif

    assign imemReqValid = live_q && (state_q == FETCH) && !idle_q;
    assign imemReqAddr  = pc_q;
    assign req_fire     = imemReqValid && imemReqReady;
    assign resp_uop     = {pc_q, imemRespData, 1'b0};
    assign d.valid      = valid_q;
    assign uopOut       = uop_q;

    // Hold off requests until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Stage registers: FSM state, pc, output uop and skid entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            uop_q   <= '0;
            skid_q  <= '0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            uop_q   <= uop_d;
            skid_q  <= skid_d;
            idle_q  <= idle_d;
        end
    end

    // Next state; redirect flushes and wins over everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = d.stall ? valid_q : 1'b0;
        uop_d   = uop_q;
        skid_d  = skid_q;
        idle_d  = idle_q;
        if (redirectValid) begin
            pc_d    = redir_pc;
            valid_d = 1'b0;
            skid_d  = '0;
            idle_d  = redir_bad;
            if (redir_bad) begin
                uop_d   = {redirectPc, 32'h0, 1'b1};
                valid_d = 1'b1;
            end
            unique case (state_q)
                FETCH: state_d = req_fire ? DRAIN : FETCH;
                WAIT,
                DRAIN: state_d = imemRespValid ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imemRespValid) begin
                        if (!valid_q || !d.stall) begin
                            uop_d   = resp_uop;
                            valid_d = 1'b1;
                            pc_d    = pc_q + 32'd4;
                            state_d = FETCH;
                        end else begin
                            skid_d  = resp_uop;
                            state_d = HOLD;
                        end
                    end
                end
                DRAIN: begin
                    if (imemRespValid) begin
                        state_d = FETCH;
                    end
                end
                HOLD: begin
                    if (!d.stall) begin
                        uop_d   = skid_q;
                        valid_d = 1'b1;
                        skid_d  = '0;
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a stream-level model of the
// uops that must leave the stage and a small latency-programmable imem.

module tb_fetch_stage;
    import Uop::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    fetch_t      uopOut;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        redirectValid;
    logic [31:0] redirectPc;

    pipeline_if pif ();

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int lat = 1;

    logic [31:0] xfer_pc[$];
    int          xfer_cyc[$];
    logic [31:0] req_addr[$];
    int          req_cyc[$];

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst           (rst),
        .d             (pif),
        .uopOut        (uopOut),
        .imemReqValid  (imemReqValid),
        .imemReqAddr   (imemReqAddr),
        .imemReqReady  (imemReqReady),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkuop(input string name, input fetch_t act,
                          input fetch_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got pc=%h enc=%h mis=%b expected pc=%h enc=%h mis=%b",
                     name, act.pc, act.enc, act.misaligned,
                     exp.pc, exp.enc, exp.misaligned);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc_n);
    endtask

    // Instruction memory: one response after lat cycles per accepted request.
    logic        m_pending = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    initial begin
        imemRespValid = 1'b0;
        imemRespData  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_pending = 1'b0;
            end else begin
                if (imemRespValid) m_pending = 1'b0;
                if (imemReqValid && imemReqReady) begin
                    chk1("one_outstanding", m_pending, 1'b0);
                    m_pending = 1'b1;
                    m_addr    = imemReqAddr;
                    m_cnt     = lat;
                    req_addr.push_back(imemReqAddr);
                    req_cyc.push_back(cyc_n);
                end
            end
            @(posedge clk);
            #1;
            imemRespValid = 1'b0;
            if (m_pending && rst) begin
                if (m_cnt <= 1) begin
                    imemRespValid = 1'b1;
                    imemRespData  = mem(m_addr);
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Stream model: every transferred uop is the next sequential pc since
    // reset or the last redirect, carrying that word of memory.
    logic [31:0] exp_pc;
    logic        dead;
    logic        mis_pend;
    logic [31:0] mis_pc;
    logic        have_prev;
    logic        prev_valid;
    logic        prev_stall;
    logic        prev_redir;
    fetch_t      prev_uop;

    always @(negedge clk) begin
        if (!rst) begin
            exp_pc    <= 32'h0000_0100;
            dead      <= 1'b0;
            mis_pend  <= 1'b0;
            mis_pc    <= '0;
            have_prev <= 1'b0;
        end else begin
            if (have_prev && prev_valid && prev_stall && !prev_redir) begin
                chk1("hold_valid", pif.valid, 1'b1);
                chkuop("hold_uop", uopOut, prev_uop);
            end
            if (pif.valid && !pif.stall) begin
                xfer_pc.push_back(uopOut.pc);
                xfer_cyc.push_back(cyc_n);
`ifdef FETCH_MISALIGN_CHECK_EN
                if (mis_pend) begin
                    chkuop("xfer_misaligned", uopOut, {mis_pc, 32'h0, 1'b1});
                    mis_pend <= 1'b0;
                end else if (dead) begin
                    timeout("xfer_while_idle");
                end else begin
                    chkuop("xfer", uopOut, {exp_pc, mem(exp_pc), 1'b0});
                    exp_pc <= exp_pc + 32'd4;
                end
`else
                chkuop("xfer", uopOut, {exp_pc, mem(exp_pc), 1'b0});
                exp_pc <= exp_pc + 32'd4;
`endif
            end
            if (redirectValid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirectPc[1:0] != 2'b00) begin
                    mis_pend <= 1'b1;
                    dead     <= 1'b1;
                    mis_pc   <= redirectPc;
                end else begin
                    mis_pend <= 1'b0;
                    dead     <= 1'b0;
                    exp_pc   <= redirectPc;
                end
`else
                exp_pc <= {redirectPc[31:2], 2'b00};
`endif
            end
            prev_valid <= pif.valid;
            prev_stall <= pif.stall;
            prev_redir <= redirectValid;
            prev_uop   <= uopOut;
            have_prev  <= 1'b1;
        end
    end

    task automatic wait_xfer(input int n, input string name);
        int k = 0;
        while (xfer_pc.size() < n && k < 80) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (xfer_pc.size() < n) timeout(name);
    endtask

    task automatic wait_accept(input string name);
        int k = 0;
        bit hit = 0;
        while (!hit && k < 80) begin
            @(negedge clk);
            hit = imemReqValid && imemReqReady;
            k++;
        end
        if (!hit) timeout(name);
    endtask

    task automatic redirect(input logic [31:0] target, output int rc);
        @(posedge clk);
        #1;
        redirectValid = 1'b1;
        redirectPc    = target;
        rc            = cyc_n;
        @(posedge clk);
        #1;
        redirectValid = 1'b0;
    endtask

    initial begin
        int          base;
        int          n0;
        int          nreq;
        int          rc;
        int          fcyc;
        logic [31:0] x;

        pif.stall     = 1'b0;
        imemReqReady  = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = '0;

        repeat (3) @(negedge clk);
        chk1("rst_valid", pif.valid, 1'b0);
        chkuop("rst_uop", uopOut, '0);
        chk1("rst_req", imemReqValid, 1'b0);
        rst = 1'b1;
        #1;
        chk1("req_before_edge", imemReqValid, 1'b0);
        @(negedge clk);
        chk1("req_after_edge", imemReqValid, 1'b1);
        chk32("req_addr_first", imemReqAddr, 32'h0000_0100);

        // Back-to-back stream from RESET_PC at one uop per two cycles.
        base = xfer_pc.size();
        wait_xfer(base + 3, "stream");
        chk32("stream_pc0", xfer_pc[base], 32'h0000_0100);
        chk32("stream_pc1", xfer_pc[base + 1], 32'h0000_0104);
        chk32("stream_pc2", xfer_pc[base + 2], 32'h0000_0108);
        chk32("stream_gap01", xfer_cyc[base + 1] - xfer_cyc[base], 2);
        chk32("stream_gap12", xfer_cyc[base + 2] - xfer_cyc[base + 1], 2);

        // Five-cycle stall while a response lands in the skid entry.
        wait_xfer(xfer_pc.size() + 1, "pre_stall");
        x = xfer_pc[xfer_pc.size() - 1];
        @(posedge clk);
        #1;
        pif.stall = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk1("stall_valid", pif.valid, 1'b1);
        chk32("stall_pc", uopOut.pc, x + 32'd4);
        @(posedge clk);
        #1;
        pif.stall = 1'b0;
        fcyc = cyc_n;
        n0 = xfer_pc.size();
        wait_xfer(n0 + 2, "post_stall");
        chk32("unstall_pc0", xfer_pc[n0], x + 32'd4);
        chk32("unstall_cyc0", xfer_cyc[n0], fcyc);
        chk32("unstall_pc1", xfer_pc[n0 + 1], x + 32'd8);
        chk32("unstall_cyc1", xfer_cyc[n0 + 1], fcyc + 1);

        // Redirect while waiting on a slow response.
        lat = 3;
        wait_accept("slow_accept");
        redirect(32'h0000_0200, rc);
        nreq = req_addr.size();
        base = xfer_pc.size();
        wait_xfer(base + 1, "redir_wait");
        chk32("redir_wait_pc", xfer_pc[base], 32'h0000_0200);
        chk32("redir_wait_req", req_addr[nreq], 32'h0000_0200);
        chk32("redir_wait_reqcyc", req_cyc[nreq], rc + 3);

        // Redirect in the same cycle as a response.
        lat = 1;
        wait_accept("fast_accept");
        @(posedge clk);
        #1;
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0200;
        rc            = cyc_n;
        @(negedge clk);
        chk1("redir_resp_same", imemRespValid, 1'b1);
        @(posedge clk);
        #1;
        redirectValid = 1'b0;
        nreq = req_addr.size();
        base = xfer_pc.size();
        wait_xfer(base + 1, "redir_resp");
        chk32("redir_resp_req", req_addr[nreq], 32'h0000_0200);
        chk32("redir_resp_reqcyc", req_cyc[nreq], rc + 1);
        chk32("redir_resp_pc", xfer_pc[base], 32'h0000_0200);

        // pc wraps past the top of the address space.
        redirect(32'hFFFF_FFFC, rc);
        nreq = req_addr.size();
        base = xfer_pc.size();
        wait_xfer(base + 2, "wrap");
        chk32("wrap_req0", req_addr[nreq], 32'hFFFF_FFFC);
        chk32("wrap_req1", req_addr[nreq + 1], 32'h0000_0000);
        chk32("wrap_pc1", xfer_pc[base + 1], 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect(32'h0000_0202, rc);
        nreq = req_addr.size();
        base = xfer_pc.size();
        wait_xfer(base + 1, "misalign");
        chk32("misalign_pc", xfer_pc[base], 32'h0000_0202);
        repeat (20) @(negedge clk);
        chk32("misalign_noreq", req_addr.size(), nreq);
        chk1("misalign_idle", imemReqValid, 1'b0);
        redirect(32'h0000_0400, rc);
        base = xfer_pc.size();
        wait_xfer(base + 1, "misalign_resume");
        chk32("misalign_resume_pc", xfer_pc[base], 32'h0000_0400);
`else
        redirect(32'h0000_0206, rc);
        base = xfer_pc.size();
        wait_xfer(base + 1, "align_force");
        chk32("align_force_pc", xfer_pc[base], 32'h0000_0204);
`endif

        repeat (6) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
